// File: rtl/cordic_sequencer_pkg.sv
// Shared definitions for the CORDIC iteration sequencer.
// Holds the FSM state encoding, the system/mode encodings, the default
// count-width types and the hyperbolic shift values that must be executed twice.
package cordic_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  typedef enum logic {
    SysHyperbolic = 1'b0,
    SysCircular   = 1'b1
  } system_e;

  typedef enum logic {
    ModeVectoring = 1'b0,
    ModeRotation  = 1'b1
  } mode_e;

  // Default width of iteration count / shift fields.
  localparam int unsigned CntW = 5;

  typedef logic [CntW-1:0] cnt_t;
  // One bit wider so all-ones can mean "no overflow seen".
  typedef logic [CntW:0]   ov_step_t;

  // Hyperbolic CORDIC only converges if these shifts are executed twice.
  localparam int unsigned HypRepeatLo = 4;
  localparam int unsigned HypRepeatHi = 13;

endpackage

// File: rtl/cordic_sequencer_if.sv
// Bundle of the sequencer's job, core and result signals.
// slave  : the sequencer side (accepts jobs, drives the core state, returns results).
// master : the environment side (issues jobs, hosts the combinational core, takes results).
interface cordic_sequencer_if #(
  parameter int unsigned P_WIDTH = 32,
  parameter int unsigned P_CNT_W = 5
);
  // Job request
  logic               start_valid;
  logic               start_ready;
  logic               start_system;
  logic               start_mode;
  logic [P_CNT_W-1:0] start_iter;
  logic [P_WIDTH-1:0] start_x;
  logic [P_WIDTH-1:0] start_y;
  logic [P_WIDTH-1:0] start_z;
  // Combinational core link
  logic [P_WIDTH-1:0] core_x;
  logic [P_WIDTH-1:0] core_y;
  logic [P_WIDTH-1:0] core_z;
  logic [P_CNT_W-1:0] core_shift;
  logic               core_system;
  logic               core_mode;
  logic [P_WIDTH-1:0] core_x_nxt;
  logic [P_WIDTH-1:0] core_y_nxt;
  logic [P_WIDTH-1:0] core_z_nxt;
  logic               core_x_ov;
  logic               core_y_ov;
  logic               core_z_ov;
  // Result
  logic               res_valid;
  logic               res_ready;
  logic [P_WIDTH-1:0] res_x;
  logic [P_WIDTH-1:0] res_y;
  logic [P_WIDTH-1:0] res_z;
  logic [2:0]         res_ov;
  logic [P_CNT_W:0]   res_ov_step;

  modport slave (
    input  start_valid, start_system, start_mode, start_iter, start_x, start_y, start_z,
    output start_ready,
    output core_x, core_y, core_z, core_shift, core_system, core_mode,
    input  core_x_nxt, core_y_nxt, core_z_nxt, core_x_ov, core_y_ov, core_z_ov,
    output res_valid, res_x, res_y, res_z, res_ov, res_ov_step,
    input  res_ready
  );

  modport master (
    output start_valid, start_system, start_mode, start_iter, start_x, start_y, start_z,
    input  start_ready,
    input  core_x, core_y, core_z, core_shift, core_system, core_mode,
    output core_x_nxt, core_y_nxt, core_z_nxt, core_x_ov, core_y_ov, core_z_ov,
    input  res_valid, res_x, res_y, res_z, res_ov, res_ov_step,
    output res_ready
  );

endinterface

// File: rtl/cordic_shift_gen.sv
// Shift-index generator for the CORDIC sequencer.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   system_i   : 1 circular, 0 hyperbolic (must be valid on load and on every step)
//   load_i     : start a new sequence (circular starts at 0, hyperbolic at 1)
//   step_i     : advance to the shift of the next iteration
//   shift_o    : shift index for the current iteration
module cordic_shift_gen
  import cordic_sequencer_pkg::*;
#(
  parameter int unsigned P_CNT_W = CntW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               system_i,
  input  logic               load_i,
  input  logic               step_i,
  output logic [P_CNT_W-1:0] shift_o
);

  localparam logic [P_CNT_W-1:0] RepLo = P_CNT_W'(HypRepeatLo);
  localparam logic [P_CNT_W-1:0] RepHi = P_CNT_W'(HypRepeatHi);

  logic [P_CNT_W-1:0] shift_q, shift_d;
  logic               rep_q, rep_d;

  always_comb begin
    shift_d = shift_q;
    rep_d   = rep_q;
    if (load_i) begin
      shift_d = (system_i == SysCircular) ? '0 : P_CNT_W'(1);
      rep_d   = 1'b0;
    end else if (step_i) begin
      // rep_q marks that the first pass of a repeated shift is already done.
      if ((system_i == SysHyperbolic) && !rep_q && ((shift_q == RepLo) || (shift_q == RepHi)))
      begin
        rep_d = 1'b1;
      end else begin
        shift_d = shift_q + 1'b1;
        rep_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      rep_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      rep_q   <= rep_d;
    end
  end

  assign shift_o = shift_q;

endmodule

// File: rtl/cordic_sequencer.sv
// Iteration sequencer for an external combinational CORDIC core.
// Accepts a job, feeds the registered x/y/z state and shift index to the core
// each cycle, registers the core's next state, collects sticky overflow flags
// and the step of the first overflow, and presents the result until taken.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : job request, core link and result handshake (slave side)
module cordic_sequencer
  import cordic_sequencer_pkg::*;
#(
  parameter int unsigned P_WIDTH    = 32,
  parameter int unsigned P_MAX_ITER = 30,
  parameter int unsigned P_CNT_W    = CntW
) (
  input logic               clk,
  input logic               rst_n,
  cordic_sequencer_if.slave bus
);

  localparam logic [P_CNT_W-1:0] MaxIter = P_CNT_W'(P_MAX_ITER);

  state_e             state_q, state_d;
  logic [P_WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic               system_q, system_d, mode_q, mode_d;
  logic [P_CNT_W-1:0] cnt_q, cnt_d, step_q, step_d;
  logic [2:0]         ov_q, ov_d;
  logic [P_CNT_W:0]   ov_step_q, ov_step_d;

  logic               accept, running, shift_system;
  logic [P_CNT_W-1:0] step_inc, iter_clamped, shift;
  logic [2:0]         ov_in;

  assign accept       = (state_q == StIdle) && bus.start_valid;
  assign running      = (state_q == StRun);
  assign step_inc     = step_q + 1'b1;
  assign iter_clamped = (bus.start_iter > MaxIter) ? MaxIter : bus.start_iter;
  assign ov_in        = {bus.core_x_ov, bus.core_y_ov, bus.core_z_ov};
  // The shift generator loads in the accept cycle, before system_q is valid.
  assign shift_system = accept ? bus.start_system : system_q;

  cordic_shift_gen #(
    .P_CNT_W (P_CNT_W)
  ) u_shift_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .system_i (shift_system),
    .load_i   (accept),
    .step_i   (running),
    .shift_o  (shift)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (bus.start_valid) state_d = (iter_clamped == '0) ? StDone : StRun;
      StRun:  if (step_inc == cnt_q) state_d = StDone;
      StDone: if (bus.res_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    bus.start_ready = (state_q == StIdle);
    bus.res_valid   = (state_q == StDone);
    bus.core_x      = x_q;
    bus.core_y      = y_q;
    bus.core_z      = z_q;
    bus.core_shift  = shift;
    bus.core_system = system_q;
    bus.core_mode   = mode_q;
    bus.res_x       = x_q;
    bus.res_y       = y_q;
    bus.res_z       = z_q;
    bus.res_ov      = ov_q;
    bus.res_ov_step = ov_step_q;
  end

  // Job datapath next state
  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    system_d  = system_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    step_d    = step_q;
    ov_d      = ov_q;
    ov_step_d = ov_step_q;
    if (accept) begin
      x_d       = bus.start_x;
      y_d       = bus.start_y;
      z_d       = bus.start_z;
      system_d  = bus.start_system;
      mode_d    = bus.start_mode;
      cnt_d     = iter_clamped;
      step_d    = '0;
      ov_d      = '0;
      ov_step_d = '1;
    end else if (running) begin
      x_d    = bus.core_x_nxt;
      y_d    = bus.core_y_nxt;
      z_d    = bus.core_z_nxt;
      step_d = step_inc;
      ov_d   = ov_q | ov_in;
      if ((ov_q == 3'b000) && (ov_in != 3'b000)) ov_step_d = {1'b0, step_q};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      system_q  <= 1'b0;
      mode_q    <= 1'b0;
      cnt_q     <= '0;
      step_q    <= '0;
      ov_q      <= '0;
      ov_step_q <= '1;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      z_q       <= z_d;
      system_q  <= system_d;
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      step_q    <= step_d;
      ov_q      <= ov_d;
      ov_step_q <= ov_step_d;
    end
  end

endmodule

// File: tb/tb_cordic_sequencer.sv
// Self-checking bench for cordic_sequencer. Hosts a behavioural fixed-point
// CORDIC core (q-format angles: radians scaled by 2^29) and a job-level model.
module tb_cordic_sequencer;
  import cordic_sequencer_pkg::*;

  localparam real AngScale = 536870912.0;   // 2^29
  localparam real DatScale = 2147483648.0;  // 2^31

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cordic_sequencer_if #(.P_WIDTH(32), .P_CNT_W(5)) bus_if ();

  cordic_sequencer #(
    .P_WIDTH    (32),
    .P_MAX_ITER (30),
    .P_CNT_W    (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int checks = 0;
  int failures = 0;

  int          atan_tab[32];
  int          atanh_tab[32];
  logic [31:0] ovx_mask, ovy_mask, ovz_mask;

  // Job-level expectations
  int          exp_cnt;
  int          exp_seq[$];
  logic [31:0] exp_x, exp_y, exp_z;
  logic [2:0]  exp_ov;
  logic [5:0]  exp_ov_step;

  // Observations of the last job
  int          trace_q[$];
  int          last_lat;
  logic [31:0] got_x, got_y, got_z;
  logic [2:0]  got_ov;
  logic [5:0]  got_ov_step;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One CORDIC micro-rotation.
  function automatic void core_step(input logic [31:0] x, input logic [31:0] y,
                                    input logic [31:0] z, input int s, input logic sys,
                                    input logic mode, output logic [31:0] xn,
                                    output logic [31:0] yn, output logic [31:0] zn);
    logic signed [31:0] xs, ys, zs, xsh, ysh, ang;
    logic neg;
    xs  = x;
    ys  = y;
    zs  = z;
    xsh = xs >>> s;
    ysh = ys >>> s;
    ang = sys ? atan_tab[s] : atanh_tab[s];
    neg = mode ? zs[31] : ~ys[31];
    if (!neg) begin
      xn = sys ? xs - ysh : xs + ysh;
      yn = ys + xsh;
      zn = zs - ang;
    end else begin
      xn = sys ? xs + ysh : xs - ysh;
      yn = ys - xsh;
      zn = zs + ang;
    end
  endfunction

  // Behavioural core attached to the sequencer.
  always_comb begin
    logic [31:0] xn, yn, zn;
    xn = '0;
    yn = '0;
    zn = '0;
    core_step(bus_if.core_x, bus_if.core_y, bus_if.core_z, int'(bus_if.core_shift),
              bus_if.core_system, bus_if.core_mode, xn, yn, zn);
    bus_if.core_x_nxt = xn;
    bus_if.core_y_nxt = yn;
    bus_if.core_z_nxt = zn;
    bus_if.core_x_ov  = ovx_mask[bus_if.core_shift];
    bus_if.core_y_ov  = ovy_mask[bus_if.core_shift];
    bus_if.core_z_ov  = ovz_mask[bus_if.core_shift];
  end

  // Expected outcome of a whole job.
  task automatic model_job(input logic sys, input logic mode, input int iter,
                           input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    logic [31:0] xn, yn, zn;
    logic [2:0]  fl;
    int          i;
    exp_cnt = (iter > 30) ? 30 : iter;
    exp_seq.delete();
    if (sys) begin
      for (int k = 0; k < exp_cnt; k++) exp_seq.push_back(k);
    end else begin
      i = 1;
      while (exp_seq.size() < exp_cnt) begin
        exp_seq.push_back(i);
        if ((i == 4 || i == 13) && exp_seq.size() < exp_cnt) exp_seq.push_back(i);
        i++;
      end
    end
    exp_x = x;
    exp_y = y;
    exp_z = z;
    exp_ov = 3'b000;
    exp_ov_step = 6'h3f;
    for (int k = 0; k < exp_cnt; k++) begin
      fl = {ovx_mask[exp_seq[k]], ovy_mask[exp_seq[k]], ovz_mask[exp_seq[k]]};
      if (fl != 3'b000 && exp_ov == 3'b000) exp_ov_step = 6'(k);
      exp_ov = exp_ov | fl;
      core_step(exp_x, exp_y, exp_z, exp_seq[k], sys, mode, xn, yn, zn);
      exp_x = xn;
      exp_y = yn;
      exp_z = zn;
    end
  endtask

  // Issue a job, follow it to completion, compare, then hand the result back.
  task automatic run_job(input logic sys, input logic mode, input int iter,
                         input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                         input int hold, input bit poke);
    int   guard;
    logic stable;
    model_job(sys, mode, iter, x, y, z);
    guard = 0;
    while (!bus_if.start_ready && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check_eq("start_ready_idle", bus_if.start_ready, 1);
    bus_if.start_system = sys;
    bus_if.start_mode   = mode;
    bus_if.start_iter   = 5'(iter);
    bus_if.start_x      = x;
    bus_if.start_y      = y;
    bus_if.start_z      = z;
    bus_if.start_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus_if.start_valid = 1'b0;
    trace_q.delete();
    last_lat = 1;
    while (!bus_if.res_valid && last_lat < 100) begin
      trace_q.push_back(int'(bus_if.core_shift));
      if (poke) begin
        // Requests while busy must be ignored.
        bus_if.start_valid  = 1'($urandom);
        bus_if.start_x      = $urandom;
        bus_if.start_iter   = 5'($urandom);
        bus_if.start_system = 1'($urandom);
      end
      @(posedge clk);
      #1;
      last_lat++;
    end
    bus_if.start_valid = 1'b0;
    check_eq("res_valid", bus_if.res_valid, 1);
    check_eq("latency", last_lat, exp_cnt + 1);
    check_eq("step_count", trace_q.size(), exp_cnt);
    for (int k = 0; k < trace_q.size() && k < exp_seq.size(); k++)
      check_eq("shift_seq", trace_q[k], exp_seq[k]);
    got_x       = bus_if.res_x;
    got_y       = bus_if.res_y;
    got_z       = bus_if.res_z;
    got_ov      = bus_if.res_ov;
    got_ov_step = bus_if.res_ov_step;
    check_eq("res_x", got_x, exp_x);
    check_eq("res_y", got_y, exp_y);
    check_eq("res_z", got_z, exp_z);
    check_eq("res_ov", got_ov, exp_ov);
    check_eq("res_ov_step", got_ov_step, exp_ov_step);
    check_eq("start_ready_done", bus_if.start_ready, 0);
    stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      bus_if.start_valid = ~bus_if.start_valid;
      bus_if.start_x     = $urandom;
      @(posedge clk);
      #1;
      if (!bus_if.res_valid || bus_if.start_ready || bus_if.res_x !== got_x ||
          bus_if.res_y !== got_y || bus_if.res_z !== got_z || bus_if.res_ov !== got_ov ||
          bus_if.res_ov_step !== got_ov_step) stable = 1'b0;
    end
    bus_if.start_valid = 1'b0;
    if (hold > 0) check_eq("hold_stable", stable, 1);
    bus_if.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_if.res_ready = 1'b0;
    check_eq("post_res_valid", bus_if.res_valid, 0);
    check_eq("post_start_ready", bus_if.start_ready, 1);
  endtask

  initial begin
    logic [31:0] x0, z45;
    real         rv;
    int          hyp_ref[15];
    hyp_ref = '{1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 13};

    for (int i = 0; i < 32; i++) begin
      atan_tab[i]  = $rtoi($atan(2.0 ** (-i)) * AngScale);
      atanh_tab[i] = (i == 0) ? 0 : $rtoi($atanh(2.0 ** (-i)) * AngScale);
    end
    ovx_mask = '0;
    ovy_mask = '0;
    ovz_mask = '0;
    rst_n = 1'b0;
    bus_if.start_valid  = 1'b0;
    bus_if.start_system = 1'b0;
    bus_if.start_mode   = 1'b0;
    bus_if.start_iter   = '0;
    bus_if.start_x      = '0;
    bus_if.start_y      = '0;
    bus_if.start_z      = '0;
    bus_if.res_ready    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_res_valid", bus_if.res_valid, 0);
    check_eq("rst_start_ready", bus_if.start_ready, 1);
    check_eq("rst_res_ov", bus_if.res_ov, 0);
    check_eq("rst_res_ov_step", bus_if.res_ov_step, 6'h3f);
    check_eq("rst_core_x", bus_if.core_x, 0);
    check_eq("rst_core_shift", bus_if.core_shift, 0);
    rst_n = 1'b1;

    // Circular rotation by 45 degrees from the gain-compensated unit vector.
    x0  = 32'($rtoi(0.6072529 * DatScale));
    z45 = 32'($rtoi(0.78539816339744831 * AngScale));
    run_job(SysCircular, ModeRotation, 30, x0, 32'd0, z45, 2, 1'b0);
    check_eq("rot45_latency", last_lat, 31);
    check_eq("rot45_ov", got_ov, 0);
    rv = $itor($signed(got_x)) / DatScale - 0.70710678118654752;
    check_eq("rot45_x_tol", (rv < 1.0e-6 && rv > -1.0e-6), 1);
    rv = $itor($signed(got_y)) / DatScale - 0.70710678118654752;
    check_eq("rot45_y_tol", (rv < 1.0e-6 && rv > -1.0e-6), 1);

    // Hyperbolic shift schedule with both repeats.
    run_job(SysHyperbolic, ModeRotation, 15, 32'h1000_0000, 32'd0, 32'h0400_0000, 0, 1'b0);
    check_eq("hyp_trace_len", trace_q.size(), 15);
    for (int k = 0; k < 15 && k < trace_q.size(); k++) check_eq("hyp_shift", trace_q[k], hyp_ref[k]);

    // Single y overflow at step 7; job still runs to the end.
    ovy_mask = 32'h0000_0080;
    run_job(SysCircular, ModeRotation, 20, $urandom, $urandom, $urandom, 0, 1'b0);
    check_eq("ov_flags", got_ov, 3'b010);
    check_eq("ov_step", got_ov_step, 7);
    check_eq("ov_latency", last_lat, 21);
    ovy_mask = '0;

    // Result held for 10 cycles while requests are pulsed; next job follows.
    run_job(SysCircular, ModeVectoring, 6, 32'h2000_0000, 32'h1000_0000, 32'd0, 10, 1'b1);
    run_job(SysHyperbolic, ModeVectoring, 5, 32'h3000_0000, 32'h1000_0000, 32'd0, 0, 1'b0);

    // Reset in the middle of a 30-step job.
    bus_if.start_system = 1'b1;
    bus_if.start_mode   = 1'b1;
    bus_if.start_iter   = 5'd30;
    bus_if.start_x      = 32'h1234_5678;
    bus_if.start_y      = 32'h0000_1000;
    bus_if.start_z      = 32'h0100_0000;
    bus_if.start_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus_if.start_valid = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
    end
    check_eq("mid_shift", bus_if.core_shift, 12);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_res_valid", bus_if.res_valid, 0);
    check_eq("mid_rst_start_ready", bus_if.start_ready, 1);
    check_eq("mid_rst_x", bus_if.res_x, 0);
    check_eq("mid_rst_ov_step", bus_if.res_ov_step, 6'h3f);
    @(posedge clk);
    #1;
    check_eq("mid_rst_idle", bus_if.res_valid, 0);
    #2;
    rst_n = 1'b1;
    run_job(SysHyperbolic, ModeRotation, 0, 32'hcafe_0001, 32'h0bad_f00d, 32'h1357_9bdf, 0, 1'b0);
    check_eq("iter0_latency", last_lat, 1);
    check_eq("iter0_x", got_x, 32'hcafe_0001);

    // Over-range count is clamped.
    run_job(SysCircular, ModeRotation, 31, $urandom, $urandom, $urandom, 0, 1'b0);
    check_eq("clamp_latency", last_lat, 31);
    check_eq("clamp_steps", trace_q.size(), 30);

    // Randomized jobs.
    for (int j = 0; j < 40; j++) begin
      if ($urandom_range(0, 1) == 0) begin
        ovx_mask = '0;
        ovy_mask = '0;
        ovz_mask = '0;
      end else begin
        ovx_mask = $urandom & $urandom & $urandom & $urandom;
        ovy_mask = $urandom & $urandom & $urandom & $urandom;
        ovz_mask = $urandom & $urandom & $urandom & $urandom;
      end
      run_job(1'($urandom), 1'($urandom), $urandom_range(0, 31), $urandom, $urandom,
              $urandom, $urandom_range(0, 3), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cordic_sequencer.md
CORDIC_SEQUENCER -- requirements
Module: cordic_sequencer

Interface
REQ-001 Parameter P_WIDTH, default 32: bit width of x, y and z data words.
REQ-002 Parameter P_MAX_ITER, default 30: largest accepted iteration count.
REQ-003 Parameter P_CNT_W, default 5: width of the iteration count and shift fields.
REQ-004 clk  in  1  single clock; all state changes occur on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active low.
REQ-006 start_valid / start_ready  in / out  1 / 1  job request handshake.
REQ-007 start_system, start_mode  in  1, 1  system (1 circular, 0 hyperbolic) and mode (1 rotation, 0 vectoring).
REQ-008 start_iter  in  P_CNT_W  number of iteration steps to execute.
REQ-009 start_x, start_y, start_z  in  P_WIDTH each  initial x, y and z values.
REQ-010 core_x, core_y, core_z  out  P_WIDTH each  current state presented to the combinational CORDIC core.
REQ-011 core_shift  out  P_CNT_W  shift index for the current step.
REQ-012 core_system, core_mode  out  1, 1  registered copies of the job's system and mode.
REQ-013 core_x_nxt, core_y_nxt, core_z_nxt  in  P_WIDTH each  next state from the core.
REQ-014 core_x_ov, core_y_ov, core_z_ov  in  1 each  core overflow flags for the current step.
REQ-015 res_valid / res_ready  out / in  1 / 1  result handshake.
REQ-016 res_x, res_y, res_z  out  P_WIDTH each  final x, y and z values.
REQ-017 res_ov  out  3  sticky overflow flags, ordered {x,y,z}.
REQ-018 res_ov_step  out  P_CNT_W+1  step index of the first overflow; all-ones when no overflow occurred.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-020 start_ready SHALL be 1 only in IDLE.
REQ-021 On a start handshake, the block SHALL latch all start_* fields, clear the overflow state and the step counter, and enter RUN.
- Initial shift is 0 for circular and 1 for hyperbolic.
REQ-022 If start_iter is 0 on a start handshake, the block SHALL go directly to DONE, and the results SHALL equal the inputs.
REQ-023 If start_iter exceeds P_MAX_ITER, the block SHALL clamp the count to P_MAX_ITER.
REQ-024 In each RUN cycle, the block SHALL register core_*_nxt into the x, y and z state, increment the step counter, and advance the shift.
REQ-025 Circular shift sequence SHALL be 0,1,2,... with no repeats.
REQ-026 Hyperbolic shift sequence SHALL repeat shift 4 and shift 13 once each: 1,2,3,4,4,5,...,13,13,14,...
- The repeat is tracked by a one-bit repeat flag.
REQ-027 The block SHALL leave RUN for DONE on the cycle in which the step counter reaches the count.
- Accept-to-res_valid latency is exactly count+1 cycles.
REQ-028 On any core_*_ov in RUN, the block SHALL OR the flag into res_ov.
REQ-029 res_ov_step SHALL capture the current step only if no earlier overflow was recorded.
REQ-030 Iteration SHALL continue after an overflow; overflow does not abort the job.
REQ-031 In DONE, res_valid SHALL be 1, and res_* SHALL hold stable until the cycle res_ready is sampled high; the block then returns to IDLE.
REQ-032 A start_valid arriving while the block is busy SHALL NOT be accepted and SHALL NOT alter state.
REQ-033 core_x, core_y and core_z SHALL always equal the internal state registers, and res_x, res_y and res_z SHALL equal the same registers.
REQ-034 Arithmetic SHALL be width-preserving; the sequencer performs no arithmetic on data, only counters.

Reset
REQ-035 While rst_n is low, the block SHALL enter IDLE and clear x, y, z, counters, shift, repeat flag and res_ov, and set res_ov_step to all-ones.
- Resulting outputs: res_valid=0, start_ready=1.
REQ-036 A reset during RUN or DONE SHALL discard the job with no result produced.
- The first start handshake after rst_n rises is accepted normally.

Structure
REQ-037 A shared package SHALL hold the FSM state enum, the system/mode encodings, the P_CNT_W-derived types, and the hyperbolic repeat constants 4 and 13.
REQ-038 The block SHALL contain one sub-module, cordic_shift_gen, which holds the shift counter and repeat flag and is driven by system, load and step.
REQ-039 The CORDIC core SHALL be instantiated outside the sequencer.

Verification
REQ-040 Circular rotation: x=0.6072529 (q0.31), y=0, z=45 deg, iter=30.
- Required response: res_valid exactly 31 cycles after accept; res_x ≈ res_y ≈ 0.70711 within 1e-6; res_ov=000.
REQ-041 Hyperbolic, iter=15, core_shift traced each RUN cycle.
- Required sequence: 1,2,3,4,4,5,6,7,8,9,10,11,12,13,13.
REQ-042 Inject core_y_ov=1 at step 7 only.
- Required response: res_ov=010 and res_ov_step=7; iteration completes all steps.
REQ-043 Hold res_ready=0 for 10 cycles in DONE while pulsing start_valid.
- Required response: res_* stable, start_ready=0, and the second job is accepted only after the result handshake.
REQ-044 Assert rst_n low at step 12 of a 30-step job.
- Required response: the next cycle shows IDLE with res_valid=0 and start_ready=1; a new iter=0 job returns its inputs after 1 cycle.
REQ-045 iter=31 with P_MAX_ITER=30.
- Required response: exactly 30 steps, res_valid after 31 cycles.
